// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and width helper for serial arithmetic blocks
package serial_adder_pkg;

  // Controller states; encodings are fixed so other serial blocks can share them
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2, never below 1 so a counter always has at least one bit
  function automatic int clog2_min1(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) begin
      bits = bits + 1;
    end
    if (bits < 1) begin
      bits = 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - combinational one-bit full adder built from two half adders
module full_adder (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b,
  input  logic ci
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (
    .s (w_s0),
    .c (w_c0),
    .a (a),
    .b (b)
  );

  half_adder u_ha1 (
    .s (s),
    .c (w_c1),
    .a (w_s0),
    .b (ci)
  );

  // At most one half adder can generate a carry, so OR merges them
  assign c = w_c0 | w_c1;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - combinational one-bit half adder
module half_adder (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with valid/ready operand and result handshakes
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int             CW   = clog2_min1(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic             r_busy;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_accept;

  full_adder u_fa (
    .s  (w_s),
    .c  (w_c),
    .a  (r_a_sr[0]),
    .b  (r_b_sr[0]),
    .ci (r_carry)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign w_sum_next = w_s;
    end else begin : g_sum_wn
      assign w_sum_next = {w_s, r_sum_sr[WIDTH-1:1]};
    end
  endgenerate

  // A finished result can be swapped for new operands on the same edge
  assign in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign w_accept = in_valid && in_ready;

  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;

  // Controller, datapath shift registers and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_sum_sr    <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum_sr <= w_sum_next;
          r_carry  <= w_c;
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            // Final bit: publish the complete result alongside the state change
            r_sum       <= w_sum_next;
            r_cout      <= w_c;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
              r_a_sr  <= a;
              r_b_sr  <= b;
              r_carry <= cin;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder at WIDTH 8 and 1
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       busy;

  logic       rst1_n;
  logic       in_valid1;
  logic       in_ready1;
  logic       a1;
  logic       b1;
  logic       cin1;
  logic       out_valid1;
  logic       out_ready1;
  logic       sum1;
  logic       cout1;
  logic       busy1;

  int n_cmp;
  int n_fail;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst1_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input string tag, input logic [7:0] va, input logic [7:0] vb, input logic vc);
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    cin      = vc;
    tick();
    in_valid = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
    cin      = 1'($urandom);
  endtask

  // Called just after the accept edge; returns just after out_valid rises
  task automatic wait_result(input string tag, input logic [7:0] es, input logic ec);
    int n;
    int nb;
    n  = 0;
    nb = 0;
    while (!out_valid && n < 40) begin
      if (busy) nb++;
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd8);
    check({tag, " busy cycles"}, 32'(nb), 32'd8);
    check({tag, " sum"}, 32'(sum), 32'(es));
    check({tag, " cout"}, 32'(cout), 32'(ec));
    check({tag, " busy in done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [2:0] v1  [3];
    logic [1:0] e1  [3];
    n_cmp      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    rst1_n     = 1'b0;
    in_valid   = 1'b0;
    a          = 8'h00;
    b          = 8'h00;
    cin        = 1'b0;
    out_ready  = 1'b1;
    in_valid1  = 1'b0;
    a1         = 1'b0;
    b1         = 1'b0;
    cin1       = 1'b0;
    out_ready1 = 1'b1;

    tick();
    tick();
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    rst_n  = 1'b1;
    rst1_n = 1'b1;
    tick();

    // 1: basic add, immediate consume
    accept("t1", 8'h35, 8'h0A, 1'b0);
    wait_result("t1", 8'h3F, 1'b0);
    tick();
    check("t1 out_valid one cycle", 32'(out_valid), 32'd0);
    check("t1 in_ready idle", 32'(in_ready), 32'd1);

    // 2: carry out and full ripple
    accept("t2a", 8'hFF, 8'h01, 1'b0);
    wait_result("t2a", 8'h00, 1'b1);
    tick();
    accept("t2b", 8'hFF, 8'hFF, 1'b1);
    wait_result("t2b", 8'hFF, 1'b1);
    tick();

    // 3: backpressure holds the result
    out_ready = 1'b0;
    accept("t3", 8'h12, 8'h34, 1'b0);
    wait_result("t3", 8'h46, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("t3 held out_valid", 32'(out_valid), 32'd1);
      check("t3 held sum", 32'(sum), 32'h46);
      check("t3 held cout", 32'(cout), 32'd0);
      check("t3 in_ready low", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("t3 in_ready with out_ready", 32'(in_ready), 32'd1);
    tick();
    check("t3 consumed", 32'(out_valid), 32'd0);

    // 5: asynchronous reset at counter==3 discards the run
    accept("t5", 8'h55, 8'h11, 1'b0);
    tick();
    tick();
    tick();
    check("t5 busy before reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5 reset out_valid", 32'(out_valid), 32'd0);
    check("t5 reset busy", 32'(busy), 32'd0);
    check("t5 reset sum", 32'(sum), 32'd0);
    check("t5 reset cout", 32'(cout), 32'd0);
    check("t5 reset in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    accept("t5 after", 8'h05, 8'h03, 1'b0);
    wait_result("t5 after", 8'h08, 1'b0);
    tick();

    // 4: back-to-back accept on the consume edge
    accept("t4a", 8'h01, 8'h02, 1'b0);
    wait_result("t4a", 8'h03, 1'b0);
    in_valid = 1'b1;
    a        = 8'h80;
    b        = 8'h80;
    cin      = 1'b0;
    #1;
    check("t4 in_ready in done", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    check("t4 no bubble out_valid", 32'(out_valid), 32'd0);
    check("t4 no bubble busy", 32'(busy), 32'd1);
    wait_result("t4b", 8'h00, 1'b1);
    tick();

    // 6: WIDTH=1 instance, vectors {a,b,cin} -> {cout,sum}
    v1[0] = 3'b110; e1[0] = 2'b10;
    v1[1] = 3'b101; e1[1] = 2'b10;
    v1[2] = 3'b001; e1[2] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      check("w1 in_ready", 32'(in_ready1), 32'd1);
      in_valid1 = 1'b1;
      a1        = v1[i][2];
      b1        = v1[i][1];
      cin1      = v1[i][0];
      tick();
      in_valid1 = 1'b0;
      check("w1 busy", 32'(busy1), 32'd1);
      tick();
      check("w1 latency out_valid", 32'(out_valid1), 32'd1);
      check("w1 sum", 32'(sum1), 32'(e1[i][0]));
      check("w1 cout", 32'(cout1), 32'(e1[i][1]));
      tick();
      check("w1 consumed", 32'(out_valid1), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder, one bit per clock, LSB first.
- The per-bit arithmetic is the existing combinational half_adder, consumed through a full_adder sub-module (two half_adders plus an OR).
- A registered carry links successive bits.
- Operands arrive and the result leaves on valid/ready handshakes, so the block sits between an operand producer and a result consumer.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, cin present.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer takes result this cycle.
- sum  output  WIDTH  result bits.
- cout  output  1  final carry-out.
- busy  output  1  high while in RUN state.

Behaviour:
- Interface: one clock domain, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0. Internal shift registers, carry register and bit counter are also cleared.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is combinational from state and out_ready.
- Accept = in_valid && in_ready at a rising edge. On accept:
  - a, b are loaded into shift registers.
  - carry register <= cin.
  - counter <= 0.
  - state -> RUN.
  - Inputs are sampled only on accept; a, b, cin are don't-care otherwise.
- RUN, each edge:
  - full_adder(a_sr[0], b_sr[0], carry) produces s and c.
  - sum_sr <= {s, sum_sr[WIDTH-1:1]}.
  - carry <= c.
  - a_sr and b_sr shift right by 1.
  - counter++.
  - On the edge where counter==WIDTH-1, state -> DONE.
- Latency: out_valid rises exactly WIDTH cycles after the accept edge.
- DONE:
  - out_valid=1, sum=sum_sr, cout=carry.
  - Outputs are held stable while out_ready=0, with no limit on the wait.
- Handshake: when out_valid && out_ready at an edge, the result is consumed.
  - If in_valid is also high, the new operands are accepted on that same edge and state -> RUN (back-to-back, no bubble).
  - Otherwise state -> IDLE.
- Output values: sum/cout keep their last value in IDLE and RUN, but are only meaningful while out_valid=1. out_valid=0 in IDLE and RUN.
- in_valid during RUN is ignored (in_ready=0); the producer must hold its operands.
- Counter width is max(1, $clog2(WIDTH)).
- WIDTH=1: RUN lasts one cycle.
- Arithmetic: {cout, sum} == a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- Reset asserted mid-RUN or in DONE aborts immediately: all state returns to reset values and the in-flight result is discarded.

Decomposition:
- Shared header serial_adder_defs.vh holds:
  - state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a CLOG2 helper macro/function, reused by later serial arithmetic blocks.
- One sub-module: full_adder(s, c, a, b, ci).
  - Two half_adder instances plus an OR for the carry.
  - Port order follows half_adder (outputs first).
  - Purely combinational, instantiated once in serial_adder.

Test Plan:
1. WIDTH=8, a=0x35, b=0x0A, cin=0, out_ready=1 -> sum=0x3F, cout=0. out_valid rises exactly 8 cycles after the accept edge and lasts 1 cycle. busy=1 for those 8 cycles.
2. WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1 (full carry ripple).
3. Backpressure: a=0x12, b=0x34, out_ready=0 for 5 cycles after out_valid rises -> sum=0x46, cout=0 held constant. in_ready stays 0 throughout. The result is consumed on the first cycle with out_ready=1.
4. Back-to-back: in_valid held with a second pair (0x80+0x80) in the cycle the first result (0x01+0x02) is consumed -> first sum=0x03. The second accept happens on the same edge, with no IDLE cycle. The second result is sum=0x00, cout=1, valid 8 cycles later.
5. Reset mid-operation: pulse rst_n low for 1 cycle at counter==3 of a run -> out_valid, busy, sum and cout go to 0 immediately, with no clock edge needed. The next transaction (0x05+0x03) gives sum=0x08.
6. WIDTH=1 instance: a=1, b=1, cin=0 -> sum=0, cout=1, latency 1 cycle. a=1, b=0, cin=1 -> sum=0, cout=1. a=0, b=0, cin=1 -> sum=1, cout=0.
